// File: rtl/rs232tx_arbiter.sv
// Four-lane byte arbiter for a single serial TX; round-robin with burst lock. Accept->tx_we = 1 cycle.
// Backpressure: req_ready is withheld while tx_busy=1, while loading and while waiting on the transmitter.
module rs232tx_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_we,
    input  logic        tx_busy,
    output logic [1:0]  owner,
    output logic        locked
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        locked_q, locked_d;
    logic [7:0]  burst_q, burst_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] idle_q, idle_d;

    logic [1:0]  win;
    logic        win_vld;
    logic [1:0]  lane;
    logic [8:0]  burst_inc;
    logic [15:0] idle_inc;

    // A held lock restricts candidates to the owner; otherwise scan upward from the pointer.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        lane    = '0;
        if (locked_q) begin
            win     = owner_q;
            win_vld = req_valid[owner_q];
        end else begin
            for (int k = 3; k >= 0; k--) begin
                lane = ptr_q + 2'(k);
                if (req_valid[lane]) begin
                    win     = lane;
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        locked_d  = locked_q;
        burst_d   = burst_q;
        tx_data_d = tx_data_q;
        idle_d    = idle_q;
        req_ready = '0;
        tx_we     = 1'b0;
        burst_inc = {1'b0, burst_q} + 9'd1;
        idle_inc  = idle_q + 16'd1;
        case (state_q)
            IDLE: begin
                if (!tx_busy && win_vld) begin
                    req_ready[win] = 1'b1;
                    tx_data_d      = req_data[{win, 3'b000} +: 8];
                    owner_d        = win;
                    idle_d         = '0;
                    state_d        = LOAD;
                    if (!req_last[win] && (burst_inc < 9'(MAX_BURST))) begin
                        locked_d = 1'b1;
                        burst_d  = burst_inc[7:0];
                    end else begin
                        locked_d = 1'b0;
                        burst_d  = '0;
                        ptr_d    = win + 2'd1;
                    end
                end else if (locked_q && !req_valid[owner_q]) begin
                    // Owner went quiet mid-burst: release the lock once the idle budget is spent.
                    if (idle_inc == 16'(LOCK_TIMEOUT)) begin
                        locked_d = 1'b0;
                        burst_d  = '0;
                        idle_d   = '0;
                        ptr_d    = owner_q + 2'd1;
                    end else begin
                        idle_d = idle_inc;
                    end
                end
            end
            LOAD: begin
                tx_we   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset wins in its own cycle: no strobe leaves while it is asserted.
        if (reset) begin
            req_ready = '0;
            tx_we     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            locked_q  <= 1'b0;
            burst_q   <= '0;
            tx_data_q <= '0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            locked_q  <= locked_d;
            burst_q   <= burst_d;
            tx_data_q <= tx_data_d;
            idle_q    <= idle_d;
        end
    end

    assign tx_data = tx_data_q;
    assign owner   = owner_q;
    assign locked  = locked_q;

endmodule

// File: tb/tb_rs232tx_arbiter.sv
// Random four-lane traffic against a rule-level arbiter model; a separate monitor scores tx_we bytes.
module tb_rs232tx_arbiter;
    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        tx_busy;
    logic [1:0]  owner;
    logic        locked;

    rs232tx_arbiter #(.MAX_BURST(MAXB), .LOCK_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_we(tx_we),
        .tx_busy(tx_busy), .owner(owner), .locked(locked)
    );

    initial forever #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit armed = 0;
    bit done = 0;
    bit final_done = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    typedef struct {
        logic [7:0] dat;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter and external activity
    int  xcnt = 0;
    bit  ext_en = 0, ext_busy = 0, force_busy = 0;
    assign tx_busy = (xcnt != 0) | ext_busy | force_busy;

    // Reference model: arbitration rules expressed on lane indices and cycle stamps
    int         m_owner = 0, m_ptr = 0, m_burst = 0, m_idle = 0;
    int         m_wait_start = 0, m_last_acc = -10;
    bit         m_locked = 0, m_waiting = 0;
    logic [7:0] m_txdata = '0;

    initial forever begin
        @(negedge clock);
        begin
            int         win;
            bit         idle;
            logic [3:0] e_rdy;
            bit         e_we;
            exp_t       e;
            win   = -1;
            e_rdy = '0;
            idle  = !m_waiting;
            e_we  = (cyc == m_last_acc + 1) && !reset;
            if (!reset && idle && !tx_busy) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) win = m_owner;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (win < 0 && req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
                end
            end
            if (win >= 0) e_rdy[win] = 1'b1;
            if (armed) begin
                chk("req_ready", req_ready, e_rdy);
                chk("tx_we", tx_we, e_we);
                chk("owner", owner, m_owner);
                chk("locked", locked, m_locked);
                chk("tx_data_reg", tx_data, m_txdata);
            end
            if (reset) begin
                m_owner = 0; m_ptr = 0; m_burst = 0; m_idle = 0;
                m_locked = 0; m_waiting = 0; m_txdata = '0; m_last_acc = -10;
                exp_q.delete();
                armed = 1;
            end else if (win >= 0) begin
                m_txdata = req_data[8*win +: 8];
                e.dat = m_txdata;
                e.due = cyc + 1;
                exp_q.push_back(e);
                m_owner = win;
                m_idle  = 0;
                if (!req_last[win] && (m_burst + 1 < MAXB)) begin
                    m_locked = 1;
                    m_burst++;
                end else begin
                    m_locked = 0;
                    m_burst  = 0;
                    m_ptr    = (win + 1) % 4;
                end
                m_waiting    = 1;
                m_wait_start = cyc + 2;
                m_last_acc   = cyc;
            end else if (idle) begin
                if (m_locked && !req_valid[m_owner]) begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        m_locked = 0;
                        m_burst  = 0;
                        m_idle   = 0;
                        m_ptr    = (m_owner + 1) % 4;
                    end
                end
            end else if (cyc >= m_wait_start && !tx_busy) begin
                m_waiting = 0;
            end
        end
    end

    // Monitor: every tx_we must match the oldest expected byte, on time and well spaced
    initial begin
        logic prev_we;
        exp_t e;
        prev_we = 1'b0;
        forever begin
            @(negedge clock);
            if (armed) begin
                if (tx_we === 1'b1) begin
                    chk("we_spacing_busy", {prev_we, tx_busy}, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_we_unexpected: strobe with data %0h, expected no write (cycle %0d)", tx_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", tx_data, e.dat);
                        chk("tx_latency", cyc, e.due);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_we_missing: no strobe for byte %0h due at cycle %0d (now %0d)", exp_q[0].dat, exp_q[0].due, cyc);
                    e = exp_q.pop_front();
                end
            end
            prev_we = tx_we;
            if (done && !final_done) begin
                chk("drain_empty", exp_q.size(), 0);
                final_done = 1;
            end
        end
    end

    // Stimulus
    int         gap[4], rem[4], seq[4];
    bit         gen_on = 0;
    logic [3:0] acc;
    logic       we_seen;

    task automatic step();
        @(negedge clock);
        acc     = req_valid & req_ready;
        we_seen = tx_we;
        @(posedge clock);
        #1;
        if (xcnt > 0) xcnt--;
        if (we_seen) xcnt = $urandom_range(10, 2);
        // Never raise external activity in the cycle the arbiter is loading.
        if (!ext_en) ext_busy = 0;
        else if (acc == 0 && $urandom_range(15, 0) == 0) ext_busy = !ext_busy;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                req_valid[i] = 1'b0;
                seq[i]++;
                rem[i]--;
                if (rem[i] <= 0) begin
                    rem[i] = $urandom_range(6, 1);
                    gap[i] = $urandom_range(3, 0);
                end else begin
                    gap[i] = ($urandom_range(7, 0) == 0) ? $urandom_range(14, 5) : 0;
                end
            end
            if (!req_valid[i]) begin
                if (gap[i] > 0) gap[i]--;
                else if (gen_on) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = 8'((i << 6) | (seq[i] & 63));
                    req_last[i]         = (rem[i] == 1);
                end
            end
        end
    endtask

    task automatic wait_any_acc();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (acc == 0 && n < 500);
        if (acc == 0) begin
            $display("FAIL wait_accept: no grant within 500 cycles, expected one");
            $fatal(1, "bench stopped: grant wait expired");
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            gap[i] = 0;
            rem[i] = $urandom_range(6, 1);
            seq[i] = 0;
        end
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();

        // Lone byte on lane 0
        req_data[7:0] = 8'h41;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        wait_any_acc();
        repeat (20) step();

        // Random contention, bursts and idle gaps, then with external busy phases
        gen_on = 1;
        repeat (3000) step();
        ext_en = 1;
        repeat (2000) step();
        ext_en = 0;
        repeat (5) step();

        // Reset landing in the load cycle drops the accepted byte
        wait_any_acc();
        reset = 1'b1;
        step();
        reset = 1'b0;

        // External busy in IDLE blocks every grant
        force_busy = 1;
        repeat (30) step();
        force_busy = 0;
        repeat (200) step();

        gen_on = 0;
        repeat (300) step();
        done = 1;
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs232tx_arbiter.md
RS232TX_ARBITER -- requirements
Module: rs232tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, max bytes one owner sends per locked burst (range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, idle cycles after which a held lock is dropped (range 1..65535).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  4  requester i has a byte on req_data[8i+7:8i].
REQ-006 SHALL have port req_data  input  32  four packed byte lanes, lane i for requester i.
REQ-007 SHALL have port req_last  input  4  byte on lane i ends that requester's burst.
REQ-008 SHALL have port req_ready  output  4  one-hot accept strobe; transfer on lane i = req_valid[i] & req_ready[i].
REQ-009 SHALL have port tx_data  output  8  byte to the serial transmitter.
REQ-010 SHALL have port tx_we  output  1  one-cycle write strobe to the serial transmitter.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy flag; high from the cycle after tx_we until the stop bit ends.
REQ-012 SHALL have port owner  output  2  index of the last granted requester.
REQ-013 SHALL have port locked  output  1  burst lock held by owner.

Function
REQ-014 SHALL implement states IDLE, LOAD, WAIT.
REQ-015 IDLE: when tx_busy=0 and a candidate is valid, SHALL assert req_ready for the winner combinationally, capture its byte into tx_data, set owner, go to LOAD; otherwise stay in IDLE with req_ready=0.
REQ-016 Candidates SHALL be: owner only when locked=1; all four lanes when locked=0.
REQ-017 Unlocked winner SHALL be chosen round-robin: first valid lane scanning from pointer upward modulo 4.
REQ-018 LOAD SHALL assert tx_we=1 for exactly one cycle and go to WAIT; latency from accept to tx_we = 1 cycle.
REQ-019 WAIT SHALL return to IDLE on the first cycle tx_busy=0; tx_we SHALL never be asserted in two consecutive cycles or while tx_busy=1.
REQ-020 req_ready SHALL be 0 in LOAD and WAIT; at most one req_ready bit high in any cycle.
REQ-021 On accept: burst counter increments (8 bits); lock set if req_last=0 and counter+1 < MAX_BURST, else lock cleared, counter zeroed, pointer = owner+1 mod 4.
REQ-022 Lock timeout: idle counter (16 bits) SHALL count IDLE cycles with locked=1 and req_valid[owner]=0, zero on any accept; at LOCK_TIMEOUT it SHALL clear lock, zero burst counter, set pointer = owner+1.
REQ-023 Simultaneous valid on several lanes SHALL grant exactly one; others wait without loss, holding valid and data.
REQ-024 Requesters SHALL hold req_data/req_last stable while valid and not accepted; the block samples them only in the accept cycle.
REQ-025 tx_busy=1 in IDLE (external transmitter activity) SHALL block all grants; counters still advance per REQ-022.
REQ-026 MAX_BURST=1 SHALL yield pure per-byte round-robin, locked always 0.

Reset
REQ-027 reset=1 at a clock edge SHALL force state IDLE, tx_we=0, tx_data=0, req_ready=0, owner=0, locked=0, pointer=0, both counters 0.
REQ-028 Reset asserted in LOAD SHALL suppress that tx_we; a byte already accepted is dropped, not retried.
REQ-029 Reset SHALL dominate all other inputs in the same cycle.

Verification
REQ-030 Single byte: req_valid=0001, lane0=0x41, last=1 -> req_ready=0001 one cycle, tx_we next cycle with tx_data=0x41, locked=0, pointer=1.
REQ-031 Contention: all four valid, last=1 on each, model transmitter busy 10 cycles per byte -> grant order 0,1,2,3,0; no lane starved.
REQ-032 Burst: lane2 sends 5 bytes last=0,0,0,0,1 while lane0 valid -> lane2 bytes consecutive, locked=1 during, lane0 granted next.
REQ-033 Burst cap: MAX_BURST=4, lane1 holds last=0 for 6 bytes, lane3 valid -> after 4th lane1 byte lock clears, lane3 granted next.
REQ-034 Timeout: LOCK_TIMEOUT=8, lane0 locked then drops valid, lane1 valid -> locked=0 after 8 idle cycles, lane1 granted on next IDLE cycle.
REQ-035 Reset in LOAD and busy check: assert reset during LOAD -> tx_we stays 0, all outputs at reset values; hold tx_busy=1 in IDLE -> req_ready stays 0000.
